// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the queued mult/div entry type and the register decode helper.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// Synchronous FIFO of mult/div results awaiting a free write-back slot.
// Exposes per-slot valid bits and contents so the top can build the pending mask.
module wb_md_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  rf_entry_t             entry_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output rf_entry_t             head_o,
  output logic [DEPTH-1:0]      valid_o,
  output rf_entry_t [DEPTH-1:0] entries_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  rf_entry_t [DEPTH-1:0] mem_q, mem_d;

  // A slot is writable only while invalid; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (pop_i && valid_q[rd_ptr_q]) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push_i && !valid_q[wr_ptr_q]) begin
      valid_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q]   = entry_i;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
    end
  end

  assign full_o    = &valid_q;
  assign empty_o   = ~|valid_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign valid_o   = valid_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port: write-back always wins, buffered
// mult/div results drain into idle slots, with pending mask and starve stall.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  WB_RegWriteIn,
  input  logic [REG_ADDR_W-1:0] WB_WriteRegIn,
  input  logic [DATA_W-1:0]     WB_WriteDataIn,
  input  logic                  MD_ValidIn,
  input  logic [REG_ADDR_W-1:0] MD_WriteRegIn,
  input  logic [DATA_W-1:0]     MD_DataIn,
  output logic                  MD_ReadyOut,
  output logic                  RF_WriteEnOut,
  output logic [REG_ADDR_W-1:0] RF_WriteAddrOut,
  output logic [DATA_W-1:0]     RF_WriteDataOut,
  output logic [NUM_REGS-1:0]   PendingMaskOut,
  output logic                  StallReqOut
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                  fifo_full, fifo_empty;
  rf_entry_t             fifo_head;
  logic [DEPTH-1:0]      fifo_valid;
  rf_entry_t [DEPTH-1:0] fifo_entries;
  rf_entry_t             md_entry;
  logic                  wb_active_c, push_c, pop_c;
  logic [CNT_W-1:0]      starve_q, starve_d;

  assign wb_active_c = WB_RegWriteIn && (WB_WriteRegIn != REG_ZERO);
  assign MD_ReadyOut = Rst_n && !fifo_full;
  // Writes to r0 still handshake but never occupy a slot
  assign push_c      = MD_ValidIn && MD_ReadyOut && (MD_WriteRegIn != REG_ZERO);
  assign pop_c       = Rst_n && !wb_active_c && !fifo_empty;
  assign md_entry    = '{addr: MD_WriteRegIn, data: MD_DataIn};

  wb_md_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .push_i    (push_c),
    .entry_i   (md_entry),
    .pop_i     (pop_c),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head),
    .valid_o   (fifo_valid),
    .entries_o (fifo_entries)
  );

  // Write-port grant; held idle while reset is asserted
  always_comb begin
    RF_WriteEnOut   = 1'b0;
    RF_WriteAddrOut = REG_ZERO;
    RF_WriteDataOut = '0;
    if (Rst_n) begin
      if (wb_active_c) begin
        RF_WriteEnOut   = 1'b1;
        RF_WriteAddrOut = WB_WriteRegIn;
        RF_WriteDataOut = WB_WriteDataIn;
      end else if (!fifo_empty) begin
        RF_WriteEnOut   = 1'b1;
        RF_WriteAddrOut = fifo_head.addr;
        RF_WriteDataOut = fifo_head.data;
      end
    end
  end

  // Cycles the head has waited without being drained, saturating
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop_c) begin
      starve_d = '0;
    end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign StallReqOut = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    PendingMaskOut = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        PendingMaskOut = PendingMaskOut | reg_onehot(fifo_entries[i].addr);
      end
    end
  end

endmodule
